posit_accum_prod_es2: RTL and testbench

- Streaming accumulator for ES=2, 32-bit posit dot products.
- Takes serialized product values in the accumulator format and sums them exactly within one burst.
- At end of burst, emits the serialized sum plus a truncated flag.
- Sits directly upstream of the accumulator-normalize stage: its out_data/out_truncated drive that stage's in1/truncated.

---
 rtl/posit_accum_prod_es2.sv | 205 ++++++++++++++++++++
 tb/tb_posit_accum_prod_es2.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/posit_accum_prod_es2.sv
// Exact streaming accumulator for serialized ES=2 posit products; emits sum + truncated flag at burst end.
// Latency 4 edges from accept to out_valid; one product per 4 cycles; in_ready low while busy or holding output.
module posit_accum_prod_es2 #(
   parameter int WIDTH     = 159,
   parameter int FBITS     = 147,
   parameter int MAX_SCALE = 120
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_truncated,
   output logic             out_valid,
   input  logic             out_ready
);
   localparam int MW = FBITS + 3;
   localparam logic signed [10:0] SMAX = 11'(MAX_SCALE);
   localparam logic signed [10:0] SMIN = -SMAX;
   localparam logic [WIDTH-1:0] ZERO_ENC = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] NAR_ENC  = {{(WIDTH-2){1'b0}}, 2'b10};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
   state_t st_q, st_d;

   logic [WIDTH-1:0] in_q, out_data_q;
   logic             last_q, out_trunc_q;
   logic             acc_sgn_q, acc_zero_q, acc_inf_q, acc_trunc_q, b_sgn_q;
   logic signed [8:0] acc_scale_q;
   logic [MW-1:0]    acc_mag_q, a_mag_q, b_mag_q;

   // Right shift that also reports whether any set bit fell off the bottom.
   function automatic logic [MW:0] shr_sticky(input logic [MW-1:0] m, input logic [9:0] sh);
      logic [MW-1:0] mask;
      if (sh >= 10'(MW)) return {|m, {MW{1'b0}}};
      mask = ~({MW{1'b1}} << sh);
      return {|(m & mask), m >> sh};
   endfunction

   logic signed [8:0] op_scale, al_scale;
   logic signed [9:0] diff;
   logic [MW-1:0]     op_mag, al_a, al_b;
   logic [MW:0]       shr_res;
   logic              op_zero, al_lost;

   always_comb begin
      op_scale = in_q[WIDTH-2 -: 9];
      op_zero  = in_q[0] | in_q[1];
      op_mag   = {1'b0, 1'b1, in_q[FBITS+1:2], 1'b0};
      diff     = {op_scale[8], op_scale} - {acc_scale_q[8], acc_scale_q};
      al_scale = acc_scale_q;
      al_a     = acc_mag_q;
      al_b     = op_zero ? '0 : op_mag;
      al_lost  = 1'b0;
      shr_res  = '0;
      if (acc_zero_q) begin
         al_scale = op_scale;
         al_a     = '0;
      end else if (!op_zero) begin
         if (diff >= 0) begin
            shr_res  = shr_sticky(acc_mag_q, diff);
            al_scale = op_scale;
            al_a     = shr_res[MW-1:0];
         end else begin
            shr_res  = shr_sticky(op_mag, -diff);
            al_b     = shr_res[MW-1:0];
         end
         al_lost = shr_res[MW];
      end
   end

   logic [MW-1:0] sum_mag;
   logic          sum_sgn;

   always_comb begin
      sum_mag = a_mag_q + b_mag_q;
      sum_sgn = acc_sgn_q;
      if (acc_sgn_q != b_sgn_q) begin
         if (a_mag_q >= b_mag_q) begin
            sum_mag = a_mag_q - b_mag_q;
         end else begin
            sum_mag = b_mag_q - a_mag_q;
            sum_sgn = b_sgn_q;
         end
      end
   end

   logic [7:0]        lzc;
   logic signed [10:0] ns;
   logic [MW-1:0]     nmag;
   logic              nzero, nlost, nclamp, ntrunc;
   logic [WIDTH-1:0]  nout;

   always_comb begin
      lzc = 8'(MW - 1);
      for (int i = 0; i < MW - 1; i++)
         if (acc_mag_q[i]) lzc = 8'(MW - 2 - i);
      ns     = {{2{acc_scale_q[8]}}, acc_scale_q};
      nmag   = acc_mag_q;
      nzero  = 1'b0;
      nlost  = 1'b0;
      nclamp = 1'b0;
      if (acc_mag_q[MW-1]) begin
         nmag  = acc_mag_q >> 1;
         ns    = ns + 11'sd1;
         nlost = acc_mag_q[0];
      end else if (acc_mag_q[MW-2:0] == '0) begin
         nzero = 1'b1;
         nmag  = '0;
         ns    = '0;
      end else begin
         nmag = acc_mag_q << lzc;
         ns   = ns - $signed({3'b0, lzc});
      end
      if (ns > SMAX) begin
         ns     = SMAX;
         nclamp = 1'b1;
      end else if (ns < SMIN) begin
         ns     = SMIN;
         nclamp = 1'b1;
      end
      ntrunc = acc_trunc_q | nlost | nclamp;
      if (acc_inf_q)  nout = NAR_ENC;
      else if (nzero) nout = ZERO_ENC;
      else            nout = {acc_sgn_q, ns[8:0], nmag[FBITS:1], 2'b00};
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         IDLE:    if (in_valid) st_d = ALIGN;
         ALIGN:   st_d = ADD;
         ADD:     st_d = NORM;
         NORM:    st_d = last_q ? OUT : IDLE;
         OUT:     if (out_ready) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q        <= IDLE;
         in_q        <= '0;
         last_q      <= 1'b0;
         acc_sgn_q   <= 1'b0;
         acc_scale_q <= '0;
         acc_mag_q   <= '0;
         acc_zero_q  <= 1'b1;
         acc_inf_q   <= 1'b0;
         acc_trunc_q <= 1'b0;
         a_mag_q     <= '0;
         b_mag_q     <= '0;
         b_sgn_q     <= 1'b0;
         out_data_q  <= ZERO_ENC;
         out_trunc_q <= 1'b0;
      end else begin
         st_q <= st_d;
         case (st_q)
            IDLE: if (in_valid) begin
               in_q   <= in_data;
               last_q <= in_last;
            end
            ALIGN: begin
               a_mag_q     <= al_a;
               b_mag_q     <= al_b;
               b_sgn_q     <= in_q[WIDTH-1];
               acc_scale_q <= al_scale;
               acc_trunc_q <= acc_trunc_q | al_lost;
               acc_inf_q   <= acc_inf_q | in_q[1];
            end
            ADD: begin
               acc_mag_q <= sum_mag;
               acc_sgn_q <= sum_sgn;
            end
            NORM: begin
               acc_mag_q   <= nmag;
               acc_scale_q <= ns[8:0];
               acc_sgn_q   <= nzero ? 1'b0 : acc_sgn_q;
               acc_zero_q  <= nzero;
               acc_trunc_q <= ntrunc;
               if (last_q) begin
                  out_data_q  <= nout;
                  out_trunc_q <= ntrunc | nmag[0];
               end
            end
            OUT: if (out_ready) begin
               acc_sgn_q   <= 1'b0;
               acc_scale_q <= '0;
               acc_mag_q   <= '0;
               acc_zero_q  <= 1'b1;
               acc_inf_q   <= 1'b0;
               acc_trunc_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = (st_q == IDLE) && !reset;
   assign out_valid     = (st_q == OUT);
   assign out_data      = out_data_q;
   assign out_truncated = out_trunc_q;
endmodule

// File: tb/tb_posit_accum_prod_es2.sv
// Scoreboarded bench for posit_accum_prod_es2 using hand-computed directed bursts.
module tb_posit_accum_prod_es2;
   logic         clk = 1'b0;
   logic         reset, in_last, in_valid, in_ready, out_truncated, out_valid, out_ready;
   logic [158:0] in_data, out_data;

   always #5 clk = ~clk;

   posit_accum_prod_es2 dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_truncated(out_truncated), .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct {
      logic [158:0] d;
      logic         t;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic logic [158:0] mk(input logic s, input int sc, input logic [146:0] fr,
                                       input logic inf, input logic z);
      return {s, 9'(sc), fr, inf, z};
   endfunction

   task automatic chk(input string name, input logic [158:0] act, input logic [158:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic expect_out(input logic [158:0] d, input logic t);
      exp_t e;
      e.d = d;
      e.t = t;
      sbq.push_back(e);
   endtask

   task automatic send(input logic [158:0] d, input logic l);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
      end
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic drain(input string name);
      int w = 0;
      while ((sbq.size() != 0 || !in_ready) && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk(name, 159'(sbq.size()), 159'd0);
   endtask

   // Monitor: pops one expectation per completed output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready && !reset) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_output: got %h, required no output", out_data);
            end else begin
               e = sbq.pop_front();
               chk("out_data", out_data, e.d);
               chk("out_truncated", 159'(out_truncated), 159'(e.t));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [146:0] f0, f15, f_lsb;
      logic [158:0] one, two, zero_enc, nar_enc;
      int c;
      f0       = '0;
      f15      = 147'd1 << 146;
      f_lsb    = 147'd1;
      one      = mk(0, 0, f0, 0, 0);
      two      = mk(0, 1, f0, 0, 0);
      zero_enc = mk(0, 0, f0, 0, 1);
      nar_enc  = mk(0, 0, f0, 1, 0);

      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", 159'(out_valid), 159'd0);
      chk("reset_in_ready", 159'(in_ready), 159'd0);
      chk("reset_out_data", out_data, zero_enc);
      chk("reset_out_trunc", 159'(out_truncated), 159'd0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_reset_in_ready", 159'(in_ready), 159'd1);

      // Single 1.0 with latency measurement.
      expect_out(one, 0);
      send(one, 1);
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!out_valid && c < 20);
      chk("latency_edges", 159'(c), 159'd4);
      drain("drain_single");

      expect_out(two, 0);
      send(one, 0); send(one, 1);
      expect_out(mk(0, -1, f15, 0, 0), 0);
      send(mk(0, 0, f15, 0, 0), 0); send(mk(1, -1, f15, 0, 0), 1);
      expect_out(zero_enc, 0);
      send(one, 0); send(mk(1, 0, f0, 0, 0), 1);
      expect_out(one, 1);
      send(one, 0); send(mk(0, -160, f0, 0, 0), 1);
      expect_out(mk(0, 120, f0, 0, 0), 1);
      send(mk(0, 120, f0, 0, 0), 0); send(mk(0, 120, f0, 0, 0), 1);
      expect_out(nar_enc, 0);
      send(one, 0); send(nar_enc, 0); send(mk(0, 1, f15, 0, 0), 1);
      expect_out(mk(0, -120, f0, 0, 0), 1);
      send(mk(0, -130, f0, 0, 0), 1);
      expect_out(mk(0, 0, f_lsb, 0, 0), 0);
      send(one, 0); send(mk(0, -147, f0, 0, 0), 1);
      expect_out(mk(1, 1, f0, 0, 0), 0);
      send(mk(1, 0, f0, 0, 0), 0); send(mk(1, 0, f0, 0, 0), 1);
      drain("drain_bursts");

      // Output stall: data must hold and input must stay blocked.
      @(posedge clk); #1 out_ready = 1'b0;
      expect_out(two, 0);
      send(two, 1);
      c = 0;
      while (!out_valid && c < 20) begin
         @(negedge clk);
         c++;
      end
      chk("stall_out_valid", 159'(out_valid), 159'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_out_data", out_data, two);
         chk("stall_in_ready", 159'(in_ready), 159'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      drain("drain_stall");

      // Reset during ADD of the third product discards the burst.
      send(one, 0); send(one, 0); send(one, 1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midreset_in_ready", 159'(in_ready), 159'd1);
      chk("midreset_out_valid", 159'(out_valid), 159'd0);
      chk("midreset_out_data", out_data, zero_enc);
      expect_out(two, 0);
      send(two, 1);
      drain("drain_after_reset");
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
